// File: rtl/fp_job_driver.sv
// Host-side load/collect master for the serial FP accumulator engine.
// Optional watchdog enabled by defining DRV_TIMEOUT_EN.
module fp_job_driver #(
  parameter int unsigned GAP            = 1,
  parameter int unsigned NUM_RESULTS    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic [15:0] peer_data,
  output logic        peer_ri,
  input  logic        peer_ro,
  input  logic [31:0] peer_result,
  input  logic [1:0]  peer_err,
  output logic [31:0] res_data,
  output logic [1:0]  res_err,
  output logic        res_valid,
  output logic        done,
  output logic        timeout
);

  localparam int unsigned GAP_W = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 2;
`ifdef DRV_TIMEOUT_EN
  localparam int unsigned WD_W  = 16;
`endif

  if (GAP > 15 || NUM_RESULTS < 1 || NUM_RESULTS > 255 || TIMEOUT_CYCLES > 65535) begin : g_param_chk
    $error("fp_job_driver: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_GAP, S_WAIT, S_DONE} state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_d;
  logic [CNT_W-1:0]   res_cnt, res_cnt_d;
  logic [63:0]        ops_q, ops_d;
  logic               ro_q;
  logic               rise;
  logic               busy_d, peer_ri_d, res_valid_d, done_d;
  logic [15:0]        peer_data_d;
  logic [31:0]        res_data_d;
  logic [1:0]         res_err_d;
`ifdef DRV_TIMEOUT_EN
  logic [WD_W-1:0]    wd, wd_d;
  logic               timeout_q, timeout_d;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Only a low-to-high transition of the engine flag counts as a result.
  assign rise = peer_ro & ~ro_q;

  function automatic logic [15:0] pick_word(input logic [63:0] ops, input logic [IDX_W-1:0] i);
    case (i)
      2'd0:    pick_word = ops[63:48];
      2'd1:    pick_word = ops[47:32];
      2'd2:    pick_word = ops[31:16];
      default: pick_word = ops[15:0];
    endcase
  endfunction

  // Next-state and next-output logic; outputs are registered from these.
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    gap_cnt_d   = gap_cnt;
    res_cnt_d   = res_cnt;
    ops_d       = ops_q;
    res_data_d  = res_data;
    res_err_d   = res_err;
    res_valid_d = 1'b0;
`ifdef DRV_TIMEOUT_EN
    wd_d        = wd;
    timeout_d   = timeout_q;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          ops_d     = {op_a, op_b};
          idx_d     = '0;
          res_cnt_d = '0;
`ifdef DRV_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (GAP != 0) begin
          gap_cnt_d = GAP_W'(GAP - 1);
          state_d   = S_GAP;
        end else if (idx == 2'd3) begin
          state_d = S_WAIT;
        end else begin
          idx_d = idx + 2'd1;
        end
      end
      S_GAP: begin
        if (gap_cnt != '0) begin
          gap_cnt_d = gap_cnt - 4'd1;
        end else if (idx == 2'd3) begin
          state_d = S_WAIT;
        end else begin
          idx_d   = idx + 2'd1;
          state_d = S_SEND;
        end
      end
      S_WAIT: begin
        if (rise) begin
          res_data_d  = peer_result;
          res_err_d   = peer_err;
          res_valid_d = 1'b1;
          res_cnt_d   = res_cnt + 8'd1;
          if (peer_err != 2'b00 || res_cnt_d == CNT_W'(NUM_RESULTS)) begin
            state_d = S_DONE;
          end
        end
`ifdef DRV_TIMEOUT_EN
        else if (wd <= 16'd1) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          wd_d = wd - 16'd1;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef DRV_TIMEOUT_EN
    // Reload on WAIT entry and on every capture; a capture beats expiry.
    if (state_d == S_WAIT && (state != S_WAIT || rise)) begin
      wd_d = WD_W'(TIMEOUT_CYCLES);
    end
`endif

    busy_d      = (state_d == S_SEND) || (state_d == S_GAP) || (state_d == S_WAIT);
    peer_ri_d   = (state_d == S_SEND);
    done_d      = (state_d == S_DONE);
    peer_data_d = busy_d ? pick_word(ops_d, idx_d) : 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      gap_cnt   <= '0;
      res_cnt   <= '0;
      ops_q     <= '0;
      ro_q      <= 1'b0;
      busy      <= 1'b0;
      peer_data <= '0;
      peer_ri   <= 1'b0;
      res_data  <= '0;
      res_err   <= '0;
      res_valid <= 1'b0;
      done      <= 1'b0;
`ifdef DRV_TIMEOUT_EN
      wd        <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      gap_cnt   <= gap_cnt_d;
      res_cnt   <= res_cnt_d;
      ops_q     <= ops_d;
      ro_q      <= peer_ro;
      busy      <= busy_d;
      peer_data <= peer_data_d;
      peer_ri   <= peer_ri_d;
      res_data  <= res_data_d;
      res_err   <= res_err_d;
      res_valid <= res_valid_d;
      done      <= done_d;
`ifdef DRV_TIMEOUT_EN
      wd        <= wd_d;
      timeout_q <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_fp_job_driver.sv
// Self-checking bench for fp_job_driver: timing model derived from the job rules.
module tb_fp_job_driver;

  localparam int G0  = 2;
  localparam int NR0 = 3;
  localparam int TO  = 16;
  localparam int G1  = 0;
  localparam int NR1 = 1;
  localparam int W0  = 4 * (G0 + 1) + 1;
  localparam int W1  = 4 * (G1 + 1) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, peer_ro, busy, peer_ri, res_valid, done, timeout;
  logic [31:0] op_a, op_b, peer_result, res_data;
  logic [1:0]  peer_err, res_err;
  logic [15:0] peer_data;

  logic        start1, peer_ro1, busy1, peer_ri1, res_valid1, done1, timeout1;
  logic [31:0] op_a1, op_b1, peer_result1, res_data1;
  logic [1:0]  peer_err1, res_err1;
  logic [15:0] peer_data1;

  fp_job_driver #(.GAP(G0), .NUM_RESULTS(NR0), .TIMEOUT_CYCLES(TO)) dut0 (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b), .busy(busy),
    .peer_data(peer_data), .peer_ri(peer_ri), .peer_ro(peer_ro), .peer_result(peer_result),
    .peer_err(peer_err), .res_data(res_data), .res_err(res_err), .res_valid(res_valid),
    .done(done), .timeout(timeout));

  fp_job_driver #(.GAP(G1), .NUM_RESULTS(NR1), .TIMEOUT_CYCLES(TO)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op_a(op_a1), .op_b(op_b1), .busy(busy1),
    .peer_data(peer_data1), .peer_ri(peer_ri1), .peer_ro(peer_ro1), .peer_result(peer_result1),
    .peer_err(peer_err1), .res_data(res_data1), .res_err(res_err1), .res_valid(res_valid1),
    .done(done1), .timeout(timeout1));

  int total = 0;
  int bad = 0;

  // Job plan: result edges as offsets from WAIT entry, optional stray pulse before WAIT.
  int          n_ed;
  int          early;
  bit          junk;
  int          ed_off[8];
  logic [31:0] ed_res[8];
  logic [1:0]  ed_err[8];

  function automatic logic [15:0] word_of(input logic [31:0] a, input logic [31:0] b, input int k);
    case (k)
      0:       return a[31:16];
      1:       return a[15:0];
      2:       return b[31:16];
      default: return b[15:0];
    endcase
  endfunction

  task automatic make_plan(input int n, input int err_at);
    int off;
    n_ed = n;
    off = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      ed_off[i] = off;
      ed_res[i] = $urandom;
      ed_err[i] = (i == err_at) ? 2'($urandom_range(1, 3)) : 2'b00;
      off += $urandom_range(2, 6);
    end
  endtask

  // Runs one job on dut0 and checks every cycle against the plan.
  task automatic run_job(input logic [31:0] a, input logic [31:0] b);
    int last, done_c;
    int ec[8];
    logic exp_ri, exp_rv;
    logic [15:0] exp_pd;
    logic [31:0] exp_rd;
    logic [1:0] exp_re;
    last = n_ed - 1;
    for (int i = n_ed - 1; i >= 0; i--) begin
      ec[i] = W0 + ed_off[i];
      if (ed_err[i] != 2'b00 || i == NR0 - 1) last = i;
    end
    done_c = ec[last] + 1;
    start = 1'b1; op_a = a; op_b = b; peer_ro = 1'b0;
    for (int t = 1; t <= done_c + 2; t++) begin
      @(negedge clk);
      exp_ri = 1'b0; exp_pd = 16'h0000;
      if (t < W0) begin
        exp_pd = word_of(a, b, (t - 1) / (G0 + 1));
        exp_ri = ((t - 1) % (G0 + 1)) == 0;
      end
      exp_rv = 1'b0; exp_rd = '0; exp_re = '0;
      for (int i = 0; i <= last; i++)
        if (ec[i] + 1 == t) begin exp_rv = 1'b1; exp_rd = ed_res[i]; exp_re = ed_err[i]; end
      total++; if (busy !== (t < done_c)) begin bad++; $display("FAIL job_busy t=%0d got=%b exp=%b", t, busy, t < done_c); end
      total++; if (peer_ri !== exp_ri) begin bad++; $display("FAIL job_ri t=%0d got=%b exp=%b", t, peer_ri, exp_ri); end
      if (t < W0 || t >= done_c) begin
        total++; if (peer_data !== exp_pd) begin bad++; $display("FAIL job_data t=%0d got=%h exp=%h", t, peer_data, exp_pd); end
      end
      total++; if (done !== (t == done_c)) begin bad++; $display("FAIL job_done t=%0d got=%b exp=%b", t, done, t == done_c); end
      total++; if (res_valid !== exp_rv) begin bad++; $display("FAIL job_rv t=%0d got=%b exp=%b", t, res_valid, exp_rv); end
      if (exp_rv) begin
        total++; if (res_data !== exp_rd || res_err !== exp_re) begin
          bad++; $display("FAIL job_result t=%0d got=%h/%b exp=%h/%b", t, res_data, res_err, exp_rd, exp_re);
        end
      end
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL job_timeout t=%0d got=%b exp=0", t, timeout); end
      if (junk && t < done_c) begin
        start = 1'($urandom_range(0, 1)); op_a = $urandom; op_b = $urandom;
      end else begin
        start = 1'b0;
      end
      peer_ro = (t == early); peer_result = $urandom; peer_err = 2'($urandom);
      for (int i = 0; i <= last; i++)
        if (ec[i] == t) begin peer_ro = 1'b1; peer_result = ed_res[i]; peer_err = ed_err[i]; end
    end
    start = 1'b0; peer_ro = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({busy, peer_ri, peer_data, res_data, res_err, res_valid, done, timeout} !== '0) begin
      bad++; $display("FAIL reset_outputs got busy=%b ri=%b data=%h res=%h err=%b rv=%b done=%b to=%b exp all 0",
                      busy, peer_ri, peer_data, res_data, res_err, res_valid, done, timeout);
    end
    total++; if ({busy1, peer_ri1, peer_data1, res_valid1, done1} !== '0) begin
      bad++; $display("FAIL reset_outputs1 got busy=%b ri=%b data=%h rv=%b done=%b exp all 0",
                      busy1, peer_ri1, peer_data1, res_valid1, done1);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    junk = 0; early = -1; n_ed = 3;
    ed_off[0] = 1; ed_res[0] = 32'h3F80_0000; ed_err[0] = 2'b00;
    ed_off[1] = 4; ed_res[1] = 32'h4000_0000; ed_err[1] = 2'b00;
    ed_off[2] = 7; ed_res[2] = 32'h4040_0000; ed_err[2] = 2'b00;
    run_job(32'h4000_0000, 32'h4120_0000);
  endtask

  task automatic test_early_ro();
    junk = 0;
    for (int i = 0; i < 3; i++) begin
      early = (i == 0) ? 5 : $urandom_range(1, W0 - 2);
      make_plan(NR0, -1);
      run_job($urandom, $urandom);
    end
    early = -1;
  endtask

  task automatic test_error();
    junk = 0; early = -1;
    make_plan(NR0, 0); ed_err[0] = 2'b10;
    run_job($urandom, $urandom);
    make_plan(NR0, 1);
    run_job($urandom, $urandom);
  endtask

  task automatic test_back_to_back();
    junk = 1;
    for (int i = 0; i < 6; i++) begin
      early = ($urandom_range(0, 1) == 1) ? $urandom_range(1, W0 - 2) : -1;
      make_plan(NR0, ($urandom_range(0, 3) == 0) ? $urandom_range(0, NR0 - 1) : -1);
      run_job($urandom, $urandom);
    end
    junk = 0; early = -1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    start = 1'b1; op_a = a; op_b = b;
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (t == 4) begin
        total++; if (peer_ri !== 1'b1 || peer_data !== a[15:0]) begin
          bad++; $display("FAIL rmid_word1 got ri=%b data=%h exp ri=1 data=%h", peer_ri, peer_data, a[15:0]);
        end
      end
    end
    reset = 1'b0;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      total++; if ({busy, peer_ri, peer_data, res_data, res_err, res_valid, done, timeout} !== '0) begin
        bad++; $display("FAIL rmid_outputs c=%0d got busy=%b ri=%b data=%h res=%h rv=%b done=%b exp all 0",
                        t, busy, peer_ri, peer_data, res_data, res_valid, done);
      end
    end
    reset = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      total++; if (done !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL rmid_idle c=%0d got done=%b busy=%b exp 0/0", t, done, busy);
      end
    end
    junk = 0; early = -1;
    make_plan(NR0, -1);
    run_job(a, b);
  endtask

  task automatic test_timeout();
    int end_c;
    logic exp_to, exp_rv;
`ifdef DRV_TIMEOUT_EN
    end_c = W0 + TO;
`else
    end_c = W0 + 46;
`endif
    start = 1'b1; op_a = $urandom; op_b = $urandom; peer_ro = 1'b0;
    for (int t = 1; t <= end_c + 2; t++) begin
      @(negedge clk);
`ifdef DRV_TIMEOUT_EN
      exp_to = (t >= end_c);
      exp_rv = 1'b0;
`else
      exp_to = 1'b0;
      exp_rv = (t == W0 + 42) || (t == W0 + 44) || (t == W0 + 46);
`endif
      total++; if (busy !== (t < end_c)) begin bad++; $display("FAIL to_busy t=%0d got=%b exp=%b", t, busy, t < end_c); end
      total++; if (done !== (t == end_c)) begin bad++; $display("FAIL to_done t=%0d got=%b exp=%b", t, done, t == end_c); end
      total++; if (timeout !== exp_to) begin bad++; $display("FAIL to_flag t=%0d got=%b exp=%b", t, timeout, exp_to); end
      total++; if (res_valid !== exp_rv) begin bad++; $display("FAIL to_rv t=%0d got=%b exp=%b", t, res_valid, exp_rv); end
      start = 1'b0;
      peer_result = $urandom; peer_err = 2'b00;
`ifdef DRV_TIMEOUT_EN
      peer_ro = 1'b0;
`else
      peer_ro = (t == W0 + 41) || (t == W0 + 43) || (t == W0 + 45);
`endif
    end
    peer_ro = 1'b0;
    junk = 0; early = -1;
    make_plan(NR0, -1);
    run_job($urandom, $urandom);
  endtask

  task automatic test_gap0();
    logic [31:0] a, b, r;
    logic [1:0] e;
    for (int j = 0; j < 3; j++) begin
      a = $urandom; b = $urandom; r = $urandom; e = 2'($urandom);
      start1 = 1'b1; op_a1 = a; op_b1 = b; peer_ro1 = 1'b0;
      for (int t = 1; t <= 8; t++) begin
        @(negedge clk);
        total++; if (peer_ri1 !== (t <= 4)) begin bad++; $display("FAIL g0_ri t=%0d got=%b exp=%b", t, peer_ri1, t <= 4); end
        if (t <= 4) begin
          total++; if (peer_data1 !== word_of(a, b, t - 1)) begin
            bad++; $display("FAIL g0_data t=%0d got=%h exp=%h", t, peer_data1, word_of(a, b, t - 1));
          end
        end
        total++; if (busy1 !== (t < W1 + 2)) begin bad++; $display("FAIL g0_busy t=%0d got=%b exp=%b", t, busy1, t < W1 + 2); end
        total++; if (res_valid1 !== (t == W1 + 2) || done1 !== (t == W1 + 2)) begin
          bad++; $display("FAIL g0_rv_done t=%0d got=%b/%b exp=%b", t, res_valid1, done1, t == W1 + 2);
        end
        if (t == W1 + 2) begin
          total++; if (res_data1 !== r || res_err1 !== e) begin
            bad++; $display("FAIL g0_result got=%h/%b exp=%h/%b", res_data1, res_err1, r, e);
          end
        end
        start1 = 1'b0;
        peer_ro1 = (t == 2) || (t == W1 + 1);
        peer_result1 = (t == W1 + 1) ? r : $urandom;
        peer_err1 = (t == W1 + 1) ? e : 2'($urandom);
      end
      peer_ro1 = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op_a = '0; op_b = '0; peer_ro = 1'b0; peer_result = '0; peer_err = '0;
    start1 = 1'b0; op_a1 = '0; op_b1 = '0; peer_ro1 = 1'b0; peer_result1 = '0; peer_err1 = '0;
    junk = 0; early = -1; n_ed = 0;
    @(negedge clk);
    test_reset();
    test_directed();
    test_early_ro();
    test_error();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    test_gap0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/fp_job_driver.md
Name: fp_job_driver

Overview:
- Host-side master for the serial floating-point accumulator engine.
- Takes one job of two IEEE-754 single operands from upstream and serialises them onto the engine's 16-bit input bus with single-cycle strobes.
- Collects the engine's result words on each rising edge of its ready line and returns them upstream with error codes.
- Sits between the system controller and the engine, owning the whole 16-bit load / ready-collect protocol.

Parameters:
- GAP, 1, idle cycles after each strobe, with data held stable (0..15).
- NUM_RESULTS, 8, results collected per job before completing (1..255).
- TIMEOUT_CYCLES, 1024, WAIT-state watchdog limit (only used with DRV_TIMEOUT_EN).

Ports:
- clk  in  1  clock, all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  job request; accepted only when busy=0.
- op_a  in  32  first operand, latched on accept.
- op_b  in  32  second operand, latched on accept.
- busy  out  1  high from accept cycle+1 until return to IDLE.
- peer_data  out  16  word to engine.
- peer_ri  out  1  word strobe to engine, one cycle per word.
- peer_ro  in  1  engine ready/result flag.
- peer_result  in  32  engine result bus.
- peer_err  in  2  engine error code.
- res_data  out  32  captured result.
- res_err  out  2  captured error code.
- res_valid  out  1  one-cycle pulse per captured result.
- done  out  1  one-cycle pulse at job end.
- timeout  out  1  sticky watchdog flag; tied 0 without the macro.

Behaviour:
- Reset (reset=0 at posedge): state IDLE; all outputs 0; word index, gap counter, result counter and ro_q cleared. Reset mid-job aborts immediately with no done pulse.
- ro_q: peer_ro registered every cycle. Rising edge = peer_ro & ~ro_q.
- IDLE: start=1 latches op_a/op_b, clears result counter and timeout, goes to SEND. busy=1 from the next cycle. start while busy is ignored.
- SEND: drive peer_data = word[idx] and peer_ri=1 for exactly one cycle.
  - Word order: A[31:16], A[15:0], B[31:16], B[15:0].
  - If GAP>0, go to GAP; otherwise stay in SEND with idx+1.
- GAP: peer_ri=0, peer_data held, for GAP cycles. Then go to SEND (next idx), or to WAIT after word 3.
  - With GAP=0, WAIT is entered directly after the 4th strobe.
- Strobe timing: accept at cycle 0; strobe k asserted at cycle 1 + k*(GAP+1).
- Edges of peer_ro seen outside WAIT are ignored. This covers the engine's mid-load ready pulse.
- WAIT: on a rising edge, register res_data<=peer_result and res_err<=peer_err, pulse res_valid the next cycle, and increment the result counter.
  - If peer_err != 0 or counter reaches NUM_RESULTS, go to DONE.
  - Otherwise stay in WAIT.
- Error policy: a nonzero peer_err always ends the job after delivering that result.
- DONE: done=1 for one cycle and busy drops in the same cycle; next state IDLE. peer_data returns to 0.
- Simultaneous edge and timeout expiry in one cycle: the capture wins and the watchdog reloads.
- The result counter is 8 bits wide and never wraps, because the job ends when it reaches NUM_RESULTS.

Optional Feature:
- Macro: DRV_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit watchdog loads TIMEOUT_CYCLES on entry to WAIT and on every capture, and decrements each WAIT cycle.
  - At 0: timeout<=1 (sticky until the next accepted start), then DONE (done pulses, no res_valid).
- Without the macro: no counter is built, timeout is constant 0, and WAIT waits indefinitely.

Test Plan:
- GAP=2, start with op_a=0x40000000, op_b=0x41200000 -> peer_ri high at cycles 1,4,7,10 with peer_data 0x4000, 0x0000, 0x4120, 0x0000; busy=1 from cycle 1.
- NUM_RESULTS=3, three peer_ro rising edges in WAIT with peer_result 0x3F800000, 0x40000000, 0x40400000 -> three res_valid pulses carrying those values, then done one cycle after the 3rd.
- peer_ro pulse during SEND/GAP, then one edge in WAIT with NUM_RESULTS=1 -> exactly one res_valid; the early edge is not captured.
- Edge in WAIT with peer_err=2'b10 and NUM_RESULTS=8 -> res_err=2'b10, res_valid, done; the job ends after 1 result.
- reset=0 during GAP after word 1, then start reissued -> all outputs 0 the cycle after reset, no done pulse; the new job resends from word 0.
- DRV_TIMEOUT_EN, TIMEOUT_CYCLES=16, no peer_ro edge -> timeout=1 and done pulse 16 cycles after WAIT entry, no res_valid; the next start clears timeout.
